// File: rtl/sdram_block_uart_tx_pkg.sv
// Shared constants and state encoding for the block-capture / UART byte streamer.
package sdram_block_uart_tx_pkg;

  localparam int MEM_DATA_BITS_DFLT = 32;
  localparam int WORDS_PER_BLOCK    = 256;
  localparam int BURST_SIZE         = 128;
  localparam int BYTES_PER_WORD     = MEM_DATA_BITS_DFLT / 8;

  localparam logic [2:0] ST_IDLE_ENC       = 3'd0;
  localparam logic [2:0] ST_CAPTURE_ENC    = 3'd1;
  localparam logic [2:0] ST_WAIT_START_ENC = 3'd2;
  localparam logic [2:0] ST_FETCH_ENC      = 3'd3;
  localparam logic [2:0] ST_SEND_ENC       = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE       = ST_IDLE_ENC,
    ST_CAPTURE    = ST_CAPTURE_ENC,
    ST_WAIT_START = ST_WAIT_START_ENC,
    ST_FETCH      = ST_FETCH_ENC,
    ST_SEND       = ST_SEND_ENC
  } state_t;

endpackage

// File: rtl/sdram_block_uart_tx_block_ram_sp.sv
// Simple dual-port block buffer: one write port, one registered read port.
module block_ram_sp #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  parameter int AW    = 8
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read data holds its value between read enables.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/sdram_block_uart_tx.sv
// Captures one burst-read image block into a local buffer, then streams it
// MSB-first as bytes to a UART transmitter over a valid/ready handshake.
module sdram_block_uart_tx #(
  parameter int MEM_DATA_BITS   = sdram_block_uart_tx_pkg::MEM_DATA_BITS_DFLT,
  parameter int WORDS_PER_BLOCK = sdram_block_uart_tx_pkg::WORDS_PER_BLOCK,
  parameter int WADDR_BITS      = 8
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     uart_oneframe_start,
  output logic                     uart_oneframe_done,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overflow_err
);

  import sdram_block_uart_tx_pkg::*;

  localparam int BPW       = MEM_DATA_BITS / 8;
  localparam int BSEL_BITS = $clog2(BPW);
  localparam int BCNT_BITS = WADDR_BITS + BSEL_BITS;
  localparam logic [WADDR_BITS-1:0] LAST_WPTR = WADDR_BITS'(WORDS_PER_BLOCK - 1);

  state_t                     r_state;
  state_t                     w_next;
  logic [WADDR_BITS-1:0]      r_wptr;
  logic [BCNT_BITS-1:0]       r_bcnt;
  logic [BCNT_BITS-1:0]       w_bcnt_nxt;
  logic                       r_done;
  logic                       r_tx_valid;
  logic [7:0]                 r_tx_data;
  logic                       r_ovf;
  logic                       w_we;
  logic                       w_re;
  logic [WADDR_BITS-1:0]      w_raddr;
  logic [MEM_DATA_BITS-1:0]   w_rdata;
  logic                       w_accept;
  logic                       w_word_end;
  logic                       w_block_end;
  logic                       w_busy_drop;

  function automatic logic [7:0] f_byte(input logic [MEM_DATA_BITS-1:0] word,
                                        input logic [BSEL_BITS-1:0]     idx);
    logic [MEM_DATA_BITS-1:0] sh;
    sh = word << {idx, 3'b000};
    return sh[MEM_DATA_BITS-1 -: 8];
  endfunction

  assign w_bcnt_nxt  = r_bcnt + 1'b1;
  assign w_accept    = (r_state == ST_SEND) && r_tx_valid && tx_ready;
  assign w_word_end  = (r_bcnt[BSEL_BITS-1:0] == {BSEL_BITS{1'b1}});
  assign w_block_end = (r_bcnt == {BCNT_BITS{1'b1}});
  assign w_we        = rd_burst_data_valid &&
                       ((r_state == ST_IDLE) || (r_state == ST_CAPTURE));
  assign w_busy_drop = rd_burst_data_valid &&
                       ((r_state == ST_WAIT_START) || (r_state == ST_FETCH) ||
                        (r_state == ST_SEND));

  // The read is launched one cycle before FETCH so the word is already on the
  // RAM output during FETCH and tx_data can be loaded straight into a flop.
  assign w_re    = ((r_state == ST_WAIT_START) && uart_oneframe_start) ||
                   (w_accept && w_word_end);
  assign w_raddr = (r_state == ST_WAIT_START) ? '0 : w_bcnt_nxt[BCNT_BITS-1:BSEL_BITS];

  block_ram_sp #(
    .DEPTH (WORDS_PER_BLOCK),
    .WIDTH (MEM_DATA_BITS),
    .AW    (WADDR_BITS)
  ) u_buf (
    .i_clk   (mem_clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (rd_burst_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (rd_burst_data_valid) w_next = ST_CAPTURE;
      ST_CAPTURE:    if (rd_burst_data_valid && (r_wptr == LAST_WPTR)) w_next = ST_WAIT_START;
      ST_WAIT_START: if (uart_oneframe_start) w_next = ST_FETCH;
      ST_FETCH:      w_next = ST_SEND;
      ST_SEND:       if (w_accept && w_word_end) w_next = w_block_end ? ST_IDLE : ST_FETCH;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wptr     <= '0;
      r_bcnt     <= '0;
      r_done     <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= (w_next == ST_IDLE);
      r_tx_valid <= (w_next == ST_SEND);
      if (w_next == ST_IDLE) r_wptr <= '0;
      else if (w_we)         r_wptr <= r_wptr + 1'b1;
      if (r_state == ST_WAIT_START) r_bcnt <= '0;
      else if (w_accept)            r_bcnt <= w_bcnt_nxt;
      if (r_state == ST_FETCH)             r_tx_data <= f_byte(w_rdata, '0);
      else if (w_accept && !w_word_end)    r_tx_data <= f_byte(w_rdata, w_bcnt_nxt[BSEL_BITS-1:0]);
      if (w_busy_drop) r_ovf <= 1'b1;
    end
  end

  assign uart_oneframe_done = r_done;
  assign tx_valid           = r_tx_valid;
  assign tx_data            = r_tx_data;
  assign overflow_err       = r_ovf;

endmodule

// File: tb/tb_sdram_block_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor pops them on handshakes.
module tb_sdram_block_uart_tx;

  logic        mem_clk;
  logic        rst;
  logic        rd_burst_data_valid;
  logic [31:0] rd_burst_data;
  logic        uart_oneframe_start;
  logic        uart_oneframe_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow_err;

  sdram_block_uart_tx dut (
    .mem_clk             (mem_clk),
    .rst                 (rst),
    .rd_burst_data_valid (rd_burst_data_valid),
    .rd_burst_data       (rd_burst_data),
    .uart_oneframe_start (uart_oneframe_start),
    .uart_oneframe_done  (uart_oneframe_done),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .overflow_err        (overflow_err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] exp_q[$];
  int         mon_bytes  = 0;
  bit         prev_hold  = 0;
  logic [7:0] prev_data  = '0;
  int         gap_state  = 0;
  bit         done_chk   = 0;
  int         rmode      = 0;
  int         rcyc       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] patf(input int pat, input int i);
    logic [7:0] b;
    b = i[7:0];
    case (pat)
      0:       return 32'(i) * 32'h0101_0101;
      1:       return {b, ~b, b ^ 8'h5A, 8'hC3};
      2:       return 32'hDEAD_0000 | 32'(i);
      default: return {8'hA5, b, 8'h3C, ~b};
    endcase
  endfunction

  // tx_ready pattern: always ready, or ready one cycle in three
  always @(posedge mem_clk) begin
    #1;
    rcyc++;
    tx_ready = (rmode == 0) ? 1'b1 : ((rcyc % 3) == 0);
  end

  always @(negedge mem_clk) begin
    if (rst) begin
      mon_bytes = 0;
      prev_hold = 0;
      gap_state = 0;
      done_chk  = 0;
    end else begin
      if (done_chk) begin
        check("done_rise", uart_oneframe_done, 1);
        done_chk = 0;
      end
      if (gap_state == 1) begin
        check("gap_fetch_valid", tx_valid, 0);
        gap_state = 2;
      end else if (gap_state == 2) begin
        check("gap_send_valid", tx_valid, 1);
        gap_state = 0;
      end
      if (prev_hold) begin
        check("hold_valid", tx_valid, 1);
        check("hold_data", tx_data, prev_data);
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_byte: actual %02h required none (queue empty)", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte", tx_data, e);
        end
        check("done_low_tx", uart_oneframe_done, 0);
        mon_bytes++;
        if (mon_bytes % 4 == 0) begin
          if (mon_bytes % 1024 == 0) done_chk = 1;
          else gap_state = 1;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input bit push);
    rd_burst_data_valid = 1'b1;
    rd_burst_data       = d;
    @(posedge mem_clk); #1;
    rd_burst_data_valid = 1'b0;
    if (push) for (int k = 3; k >= 0; k--) exp_q.push_back(d[k*8 +: 8]);
  endtask

  task automatic write_words(input int pat, input int first, input int n);
    for (int i = first; i < first + n; i++) send_word(patf(pat, i), 1);
  endtask

  task automatic first_beat(input int pat);
    check("done_before_beat", uart_oneframe_done, 1);
    send_word(patf(pat, 0), 1);
    check("done_after_beat", uart_oneframe_done, 0);
  endtask

  task automatic do_start();
    uart_oneframe_start = 1'b1;
    @(posedge mem_clk); #1;
    check("start_fetch_valid", tx_valid, 0);
    uart_oneframe_start = 1'b0;
    @(posedge mem_clk); #1;
    check("start_send_valid", tx_valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge mem_clk);
      if (exp_q.size() == 0 && uart_oneframe_done) break;
    end
    check("drained", exp_q.size(), 0);
    check("done_idle", uart_oneframe_done, 1);
    @(posedge mem_clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    rd_burst_data_valid = 1'b0;
    rd_burst_data = '0;
    uart_oneframe_start = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge mem_clk);
    #1 rst = 1'b0;
    check("rst_done", uart_oneframe_done, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ovf", overflow_err, 0);

    // basic block, ready tied high
    first_beat(0);
    write_words(0, 1, 255);
    do_start();
    wait_idle(3000);

    // backpressure
    rmode = 1;
    first_beat(0);
    write_words(0, 1, 255);
    do_start();
    wait_idle(8000);
    rmode = 0;

    // gap between bursts, early start ignored
    first_beat(1);
    write_words(1, 1, 127);
    for (int c = 0; c < 20; c++) begin
      uart_oneframe_start = (c >= 5 && c < 10);
      @(posedge mem_clk); #1;
    end
    uart_oneframe_start = 1'b0;
    check("gap_no_tx", tx_valid, 0);
    check("gap_done_low", uart_oneframe_done, 0);
    write_words(1, 128, 128);
    do_start();
    wait_idle(3000);

    // overflow: 257th beat dropped
    check("ovf_before", overflow_err, 0);
    first_beat(2);
    write_words(2, 1, 255);
    send_word(32'hBAD0_BAD0, 0);
    check("ovf_set", overflow_err, 1);
    do_start();
    wait_idle(3000);
    check("ovf_sticky", overflow_err, 1);

    // reset in the middle of SEND
    first_beat(3);
    write_words(3, 1, 255);
    do_start();
    for (int i = 0; i < 5000 && mon_bytes < 500; i++) @(negedge mem_clk);
    check("reached_500", (mon_bytes >= 500), 1);
    @(posedge mem_clk); #1;
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge mem_clk);
    #1 rst = 1'b0;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_done", uart_oneframe_done, 1);
    check("mid_rst_ovf", overflow_err, 0);
    first_beat(0);
    write_words(0, 1, 255);
    do_start();
    wait_idle(3000);

    // reader model: fetch next block only when done is high
    for (int b = 0; b < 3; b++) begin
      int w;
      for (w = 0; w < 100 && !uart_oneframe_done; w++) @(posedge mem_clk);
      check("reader_done_wait", uart_oneframe_done, 1);
      #1;
      first_beat(b + 1);
      write_words(b + 1, 1, 255);
      do_start();
      wait_idle(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", compared);
    $fatal(1, "watchdog");
  end

endmodule
